// File: rtl/tdc_multi.sv
// Multi-channel tapped-delay-line TDC: CARRY4 chains, two-flop sampling, edge detect with
// popcount fine value, shared coarse counter, fixed-priority arbiter into an FWFT FIFO.
module tdc_multi #(
   parameter int N_CH       = 4,
   parameter int TAPS       = 32,
   parameter int COARSE_W   = 32,
   parameter int FIFO_DEPTH = 16,
   localparam int FINE_W    = $clog2(TAPS + 1),
   localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_CH-1:0]     hit_in,
   input  logic [N_CH-1:0]     ch_en,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [CH_W-1:0]     m_chan,
   output logic [COARSE_W-1:0] m_coarse,
   output logic [FINE_W-1:0]   m_fine,
   output logic                overflow,
   input  logic                ovf_clr
);
   localparam int NCELL = TAPS / 4;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [3:0] CY_S  = 4'b1111;
   localparam logic [3:0] CY_DI = 4'b0000;

   typedef struct packed {
      logic [CH_W-1:0]     chan;
      logic [COARSE_W-1:0] coarse;
      logic [FINE_W-1:0]   fine;
   } rec_t;

   logic [N_CH-1:0][TAPS-1:0]     taps, s1_q, s2_q;
   logic [N_CH-1:0]               p_q, s2_lsb, det, pv_q, gnt, drop;
   logic [N_CH-1:0][FINE_W-1:0]   fine, pf_q;
   logic [N_CH-1:0][COARSE_W-1:0] pc_q;
   logic [1:0]                    arm_q;
   logic [COARSE_W-1:0]           cnt_q, cnt1_q, cnt2_q;
   logic                          ovf_q;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      for (genvar k = 0; k < NCELL; k++) begin : g_cell
         logic       ci;
         logic [3:0] co;
         if (k == 0) begin : g_first
            assign ci = hit_in[c];
         end else begin : g_next
            assign ci = g_cell[k-1].co[3];
         end
         // CARRY4 behaviour: each MUXCY passes the carry when S=1, else takes DI.
         always_comb begin
            logic cy;
            cy = ci;
            for (int i = 0; i < 4; i++) begin
               cy    = CY_S[i] ? cy : CY_DI[i];
               co[i] = cy;
            end
         end
         assign taps[c][4*k +: 4] = co;
      end
   end

   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         s2_lsb[c] = s2_q[c][0];
         fine[c]   = '0;
         for (int t = 0; t < TAPS; t++) fine[c] = fine[c] + FINE_W'(s2_q[c][t]);
      end
   end

   assign det = s2_lsb & ~p_q & ch_en;

   // P stays high until S2 carries real samples, so a line already high at release is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         p_q    <= '1;
         arm_q  <= '0;
         cnt_q  <= '0;
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         s1_q   <= taps;
         s2_q   <= s1_q;
         arm_q  <= {arm_q[0], 1'b1};
         p_q    <= arm_q[1] ? s2_lsb : '1;
         cnt_q  <= cnt_q + COARSE_W'(1);
         cnt1_q <= cnt_q;
         cnt2_q <= cnt1_q;
      end
   end

   // FIFO
   rec_t            mem_q [FIFO_DEPTH];
   rec_t            wr_rec, head;
   logic [AW-1:0]   wp_q, rp_q;
   logic [AW:0]     fcnt_q;
   logic            full, rd, wr_ok, wr_en;

   assign full  = (fcnt_q == (AW+1)'(FIFO_DEPTH));
   assign rd    = m_valid & m_ready;
   assign wr_ok = ~full | rd;
   assign gnt   = wr_ok ? (pv_q & (~pv_q + N_CH'(1))) : '0;
   assign wr_en = |gnt;
   assign drop  = det & pv_q & ~gnt;

   always_comb begin
      wr_rec = '0;
      for (int c = 0; c < N_CH; c++)
         if (gnt[c]) wr_rec = '{chan: CH_W'(c), coarse: pc_q[c], fine: pf_q[c]};
   end

   // A slot being drained this cycle can take a new hit in the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv_q <= '0;
         pc_q <= '0;
         pf_q <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (det[c] && (!pv_q[c] || gnt[c])) begin
               pv_q[c] <= 1'b1;
               pc_q[c] <= cnt2_q;
               pf_q[c] <= fine[c];
            end else if (gnt[c]) begin
               pv_q[c] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wp_q   <= '0;
         rp_q   <= '0;
         fcnt_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_q[wp_q] <= wr_rec;
            wp_q        <= wp_q + AW'(1);
         end
         if (rd) rp_q <= rp_q + AW'(1);
         fcnt_q <= fcnt_q + (AW+1)'(wr_en) - (AW+1)'(rd);
         if (|drop)        ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   assign head     = mem_q[rp_q];
   assign m_valid  = (fcnt_q != '0);
   assign m_chan   = head.chan;
   assign m_coarse = head.coarse;
   assign m_fine   = head.fine;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_tdc_multi.sv
// Bench for tdc_multi: directed scenarios plus randomized hits checked against a
// per-channel timestamp model derived from capture-edge numbering.
module tb_tdc_multi;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] hit_in, ch_en;
   logic       m_valid, m_ready;
   logic [1:0] m_chan;
   logic [3:0] m_coarse;
   logic [5:0] m_fine;
   logic       overflow, ovf_clr;

   int n_vec = 0;
   int n_err = 0;
   int ecnt  = 0;

   typedef struct { int chan; int coarse; int fine; int edge_i; } rx_t;
   rx_t rx_q[$];
   int  exp_q[4][$];

   tdc_multi #(.N_CH(4), .TAPS(32), .COARSE_W(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .hit_in(hit_in), .ch_en(ch_en),
      .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan),
      .m_coarse(m_coarse), .m_fine(m_fine), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // One clock; records a transfer if valid&ready were up going into the edge.
   task automatic tick();
      logic x;
      rx_t  r;
      x = m_valid & m_ready;
      r.chan = int'(m_chan); r.coarse = int'(m_coarse); r.fine = int'(m_fine); r.edge_i = ecnt;
      @(posedge clk); #1;
      ecnt++;
      if (x) rx_q.push_back(r);
   endtask

   task automatic do_reset();
      rst = 1'b1; hit_in = '0; ch_en = '1; m_ready = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; ecnt = 0; rx_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", m_valid); end
      n_vec++; if (m_chan !== 2'd0) begin n_err++; $display("FAIL reset_chan: got %0d want 0", m_chan); end
      n_vec++; if (m_coarse !== 4'd0) begin n_err++; $display("FAIL reset_coarse: got %0d want 0", m_coarse); end
      n_vec++; if (m_fine !== 6'd0) begin n_err++; $display("FAIL reset_fine: got %0d want 0", m_fine); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_single_hit();
      do_reset();
      repeat (10) tick();
      hit_in[2] = 1'b1;
      repeat (3) tick();
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_early: m_valid got %b want 0 after edge 12", m_valid); end
      tick();
      n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1 after edge 13", m_valid); end
      n_vec++; if (m_chan !== 2'd2) begin n_err++; $display("FAIL single_chan: got %0d want 2", m_chan); end
      n_vec++; if (m_coarse !== 4'd10) begin n_err++; $display("FAIL single_coarse: got %0d want 10", m_coarse); end
      n_vec++; if (m_fine !== 6'd32) begin n_err++; $display("FAIL single_fine: got %0d want 32", m_fine); end
      m_ready = 1'b1;
      repeat (8) tick();
      n_vec++; if (rx_q.size() != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", rx_q.size()); end
      hit_in = '0;
   endtask

   task automatic test_simultaneous();
      int e;
      do_reset();
      m_ready = 1'b1;
      repeat (5) tick();
      e = ecnt;
      hit_in = '1;
      repeat (12) tick();
      n_vec++;
      if (rx_q.size() != 4) begin
         n_err++; $display("FAIL simul_count: got %0d want 4", rx_q.size());
      end else begin
         n_vec++; if (rx_q[0].edge_i != e + 4) begin n_err++; $display("FAIL simul_latency: first xfer edge %0d want %0d", rx_q[0].edge_i, e + 4); end
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rx_q[i].chan != i || rx_q[i].coarse != (e % 16) || rx_q[i].edge_i != e + 4 + i) begin
               n_err++;
               $display("FAIL simul_rec%0d: got ch%0d c%0d edge%0d want ch%0d c%0d edge%0d",
                        i, rx_q[i].chan, rx_q[i].coarse, rx_q[i].edge_i, i, e % 16, e + 4 + i);
            end
         end
      end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_ovf: got %b want 0", overflow); end
      hit_in = '0;
   endtask

   task automatic test_back_pressure();
      int caps[6];
      do_reset();
      tick(); tick();
      for (int n = 0; n < 6; n++) begin
         caps[n] = ecnt;
         hit_in[0] = 1'b1;
         tick(); tick();
         if (n == 5) begin
            n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_ovf_before: got %b want 0", overflow); end
            ovf_clr = 1'b1;
         end
         hit_in[0] = 1'b0;
         tick();
         if (n == 5) begin
            ovf_clr = 1'b0;
            n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
         end
         tick();
      end
      n_vec++; if (m_valid !== 1'b1 || m_chan !== 2'd0 || int'(m_coarse) != caps[0] % 16) begin
         n_err++; $display("FAIL bp_head_hold: got v%b c%0d want v1 c%0d", m_valid, m_coarse, caps[0] % 16);
      end
      tick();
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
      m_ready = 1'b1;
      repeat (12) tick();
      n_vec++;
      if (rx_q.size() != 5) begin
         n_err++; $display("FAIL bp_count: got %0d want 5", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (rx_q[i].chan != 0 || rx_q[i].coarse != caps[i] % 16 || rx_q[i].fine != 32) begin
               n_err++;
               $display("FAIL bp_rec%0d: got ch%0d c%0d f%0d want ch0 c%0d f32",
                        i, rx_q[i].chan, rx_q[i].coarse, rx_q[i].fine, caps[i] % 16);
            end
         end
      end
   endtask

   task automatic test_reset_behaviour();
      rst = 1'b1; hit_in = 4'b0001; ch_en = '1; m_ready = 1'b1; ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; ecnt = 0; rx_q.delete();
      repeat (10) tick();
      n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL rst_high_hold: got %0d records want 0", rx_q.size()); end
      hit_in[0] = 1'b0; repeat (3) tick();
      hit_in[0] = 1'b1; repeat (8) tick();
      n_vec++; if (rx_q.size() != 1 || rx_q[0].chan != 0) begin n_err++; $display("FAIL rst_rearm: got %0d records want 1 on ch0", rx_q.size()); end
      m_ready = 1'b0;
      hit_in = 4'b1111;
      repeat (8) tick();
      n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rst_queued: m_valid got %b want 1", m_valid); end
      rst = 1'b1;
      #1;
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_async: m_valid got %b want 0", m_valid); end
      @(posedge clk); #1;
      hit_in = '0; rst = 1'b0; ecnt = 0; rx_q.delete(); m_ready = 1'b1;
      repeat (10) tick();
      n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL rst_stale: got %0d records want 0", rx_q.size()); end
   endtask

   task automatic test_enable_wrap();
      do_reset();
      ch_en = 4'b1101; m_ready = 1'b1;
      repeat (3) tick();
      hit_in[1] = 1'b1; repeat (8) tick(); hit_in[1] = 1'b0;
      n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL en_off: got %0d records want 0", rx_q.size()); end
      while (ecnt < 15) tick();
      hit_in[0] = 1'b1; tick();
      hit_in[0] = 1'b0; tick();
      hit_in[0] = 1'b1; tick();
      hit_in[0] = 1'b0; repeat (8) tick();
      n_vec++;
      if (rx_q.size() != 2) begin
         n_err++; $display("FAIL wrap_count: got %0d want 2", rx_q.size());
      end else begin
         n_vec++; if (rx_q[0].coarse != 15 || rx_q[1].coarse != 1) begin
            n_err++; $display("FAIL wrap_coarse: got %0d,%0d want 15,1", rx_q[0].coarse, rx_q[1].coarse);
         end
      end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_ovf: got %b want 0", overflow); end
      ch_en = '1; hit_in[1] = 1'b1; repeat (8) tick(); hit_in[1] = 1'b0;
      n_vec++; if (rx_q.size() != 3 || rx_q[rx_q.size()-1].chan != 1) begin
         n_err++; $display("FAIL en_on: got %0d records want 3 ending on ch1", rx_q.size());
      end
   endtask

   task automatic check_rx();
      rx_t r;
      while (rx_q.size() > 0) begin
         r = rx_q.pop_front();
         n_vec++;
         if (exp_q[r.chan].size() == 0) begin
            n_err++; $display("FAIL rand_extra: got ch%0d c%0d want no record", r.chan, r.coarse);
         end else begin
            int ec;
            ec = exp_q[r.chan].pop_front();
            if (r.coarse != ec || r.fine != 32) begin
               n_err++; $display("FAIL rand_rec: ch%0d got c%0d f%0d want c%0d f32", r.chan, r.coarse, r.fine, ec);
            end
         end
      end
   endtask

   // Model: a record per channel for every capture edge e>=1 where the line is high at e and low at e-1.
   task automatic test_random();
      int   dwell[4];
      logic lvl[4], prv[4];
      do_reset();
      m_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin dwell[c] = 0; lvl[c] = 1'b0; prv[c] = 1'b0; exp_q[c].delete(); end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < 4; c++) begin
            if (dwell[c] >= 4 && $urandom_range(3) == 0) begin lvl[c] = ~lvl[c]; dwell[c] = 0; end
            else dwell[c]++;
            hit_in[c] = lvl[c];
            if (lvl[c] && !prv[c] && ecnt >= 1) exp_q[c].push_back(ecnt % 16);
            prv[c] = lvl[c];
         end
         tick();
         check_rx();
      end
      hit_in = '0;
      repeat (12) begin tick(); check_rx(); end
      for (int c = 0; c < 4; c++) begin
         n_vec++; if (exp_q[c].size() != 0) begin n_err++; $display("FAIL rand_missing: ch%0d got %0d undelivered want 0", c, exp_q[c].size()); end
      end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rand_ovf: got %b want 0", overflow); end
   endtask

   initial begin
      rst = 1'b1; hit_in = '0; ch_en = '1; m_ready = 1'b0; ovf_clr = 1'b0;
      test_reset();
      test_single_hit();
      test_simultaneous();
      test_back_pressure();
      test_reset_behaviour();
      test_enable_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
